// File: rtl/bcd_updown_counter_jk.sv
// Multi-digit BCD up/down counter with parallel load and modulo limit.
// The state register is stored as JK cells driven from a per-bit J/K pair.
module bcd_updown_counter_jk #(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_COUNT  = 99
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic                    wrap,
    output logic                    load_err
);
    localparam int W = 4 * NUM_DIGITS;

    function automatic logic [W-1:0] to_bcd(input int val);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    logic [W-1:0] inc_val, dec_val, d, j, k, q_next;
    logic [3:0]   dig;
    logic         carry, borrow, digits_ok, load_ok, at_max, at_zero;
    logic         wrap_d, load_err_d;

    assign at_max  = (count == MAX_BCD);
    assign at_zero = (count == '0);
    assign tc      = up ? at_max : at_zero;

    // Ripple carry/borrow across digits; each digit rolls 9<->0 independently.
    always_comb begin
        inc_val = count;
        dec_val = count;
        carry   = 1'b1;
        borrow  = 1'b1;
        dig     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count[4*i +: 4];
            if (carry) begin
                inc_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                carry = (dig == 4'd9);
            end
            if (borrow) begin
                dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                borrow = (dig == 4'd0);
            end
        end
    end

    // Digit-wise BCD values order the same as their raw encodings.
    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
        end
        load_ok = digits_ok && (load_val <= MAX_BCD);
    end

    always_comb begin
        d          = count;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) d = load_val;
            else         load_err_d = 1'b1;
        end else if (en) begin
            if (up) begin
                d      = at_max ? '0 : inc_val;
                wrap_d = at_max;
            end else begin
                d      = at_zero ? MAX_BCD : dec_val;
                wrap_d = at_zero;
            end
        end
    end

    // JK excitation and characteristic equation; J=K=1 toggles.
    assign j      = ~count & d;
    assign k      = count & ~d;
    assign q_next = (j & ~count) | (~k & count);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= q_next;
            wrap     <= wrap_d;
            load_err <= load_err_d;
        end
    end
endmodule
